// File: rtl/mux_stream_sched.sv
// mux_stream_sched: captures an N-lane vector and streams it out one lane per
// output handshake, lane 0 first.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input vector handshake (ready only while idle)
//   in_data[N*DATA_W]     packed lanes, lane i = in_data[i*DATA_W +: DATA_W]
//   flush                 synchronous abort of the current vector
//   out_valid/out_ready   output lane handshake
//   out_data[DATA_W]      selected lane
//   out_idx[SW]           lane index of out_data
//   out_last              out_data is lane N-1
//   busy                  a captured vector is still being delivered
module mux_stream_sched #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [SW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic [N*DATA_W-1:0]   vec_q, vec_d;

  // State, index and captured vector registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  // Next-state logic; flush overrides both handshakes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_d   = in_data;
            idx_d   = '0;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + SW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Lane select from registered state only, so outputs hold during stalls
  always_comb begin
    out_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == SW'(i)) begin
        out_data = vec_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == STREAM);
  assign out_valid = busy;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == LAST_IDX) && out_valid;

endmodule

// File: tb/tb_mux_stream_sched.sv
// Bench for mux_stream_sched: two instances (N=4/DATA_W=8 and N=1/DATA_W=32)
// checked against a lane-queue reference model.
module tb_mux_stream_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N=4, DATA_W=8
  logic        a_in_valid = 1'b0, a_flush = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_idx;

  mux_stream_sched #(.N(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy)
  );

  // Instance B: N=1, DATA_W=32
  logic        b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [31:0] b_out_data;
  logic [0:0]  b_out_idx;

  mux_stream_sched #(.N(1), .DATA_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
  );

  // Reference model: lanes still owed to downstream, oldest first
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_a();
    check_eq("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    check_eq("a_busy",      32'(a_busy),      32'(qa.size() != 0));
    check_eq("a_in_ready",  32'(a_in_ready),  32'(qa.size() == 0));
    if (qa.size() != 0) begin
      check_eq("a_out_data", 32'(a_out_data), qa[0]);
      check_eq("a_out_idx",  32'(a_out_idx),  32'(4 - qa.size()));
      check_eq("a_out_last", 32'(a_out_last), 32'(qa.size() == 1));
    end else begin
      check_eq("a_idle_idx",  32'(a_out_idx),  32'd0);
      check_eq("a_idle_last", 32'(a_out_last), 32'd0);
    end
  endtask

  task automatic check_b();
    check_eq("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
    check_eq("b_busy",      32'(b_busy),      32'(qb.size() != 0));
    check_eq("b_in_ready",  32'(b_in_ready),  32'(qb.size() == 0));
    check_eq("b_out_idx",   32'(b_out_idx),   32'd0);
    check_eq("b_out_last",  32'(b_out_last),  32'(qb.size() != 0));
    if (qb.size() != 0) check_eq("b_out_data", b_out_data, qb[0]);
  endtask

  // One cycle on A: drive at negedge, check state-only outputs, advance model
  task automatic cycle_a(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    @(negedge clk);
    a_in_valid = v; a_in_data = d; a_out_ready = rdy; a_flush = fl;
    check_a();
    if (fl) begin
      qa.delete();
    end else if (qa.size() == 0) begin
      if (v) for (int i = 0; i < 4; i++) qa.push_back(32'(d[i*8 +: 8]));
    end else if (rdy) begin
      void'(qa.pop_front());
    end
  endtask

  task automatic cycle_b(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    @(negedge clk);
    b_in_valid = v; b_in_data = d; b_out_ready = rdy; b_flush = fl;
    check_b();
    if (fl) begin
      qb.delete();
    end else if (qb.size() == 0) begin
      if (v) qb.push_back(d);
    end else if (rdy) begin
      void'(qb.pop_front());
    end
  endtask

  initial begin
    int ready_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    // Reset values while rst is held
    #2;
    check_eq("rst_a_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_a_ready", 32'(a_in_ready),  32'd1);
    check_eq("rst_a_busy",  32'(a_busy),      32'd0);
    check_eq("rst_a_data",  32'(a_out_data),  32'd0);
    check_eq("rst_a_idx",   32'(a_out_idx),   32'd0);
    check_eq("rst_a_last",  32'(a_out_last),  32'd0);
    check_eq("rst_b_data",  b_out_data,       32'd0);
    check_eq("rst_b_last",  32'(b_out_last),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Sustained out_ready: four beats then idle again
    cycle_a(1, 32'h44332211, 1, 0);
    for (int i = 0; i < 4; i++) cycle_a(0, 0, 1, 0);
    cycle_a(0, 0, 1, 0);

    // Stalled delivery pattern
    cycle_a(1, 32'h44332211, 0, 0);
    for (int i = 0; i < 7; i++) cycle_a(0, 0, 1'(ready_pat[i]), 0);
    cycle_a(0, 0, 0, 0);

    // in_valid held with a second vector during streaming
    cycle_a(1, 32'h44332211, 1, 0);
    for (int i = 0; i < 10; i++) cycle_a(1, 32'hDDCCBBAA, 1, 0);
    cycle_a(0, 0, 1, 0);
    cycle_a(0, 0, 1, 0);

    // Flush on the lane 1 handshake, with an in_valid that must be dropped
    cycle_a(1, 32'h44332211, 1, 0);
    cycle_a(0, 0, 1, 0);
    cycle_a(1, 32'h99887766, 1, 1);
    cycle_a(0, 0, 1, 0);

    // Asynchronous reset between edges while lane 2 is presented
    cycle_a(1, 32'h44332211, 1, 0);
    cycle_a(0, 0, 1, 0);
    cycle_a(0, 0, 1, 0);
    cycle_a(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(a_out_valid), 32'd0);
    check_eq("arst_busy",  32'(a_busy),      32'd0);
    check_eq("arst_idx",   32'(a_out_idx),   32'd0);
    check_eq("arst_data",  32'(a_out_data),  32'd0);
    #1 rst = 1'b0;
    qa.delete();
    cycle_a(1, 32'h0D0C0B0A, 1, 0);
    for (int i = 0; i < 5; i++) cycle_a(0, 0, 1, 0);

    // Random traffic on A
    for (int i = 0; i < 400; i++)
      cycle_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0));
    cycle_a(0, 0, 0, 1);
    cycle_a(0, 0, 0, 0);

    // N=1: single beat per vector
    cycle_b(1, 32'hCAFEF00D, 1, 0);
    cycle_b(0, 0, 1, 0);
    cycle_b(0, 0, 1, 0);
    for (int i = 0; i < 200; i++)
      cycle_b(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
    cycle_b(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_stream_sched.md
MUX_STREAM_SCHED -- requirements
Module: mux_stream_sched

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the number of DATA_W lanes per input vector (N >= 1).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the lane width in bits.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  in_data holds a vector to schedule.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 in_data  input  DATA_W*N  packed lanes; lane i = in_data[i*DATA_W +: DATA_W].
REQ-009 flush  input  1  synchronous abort of the current vector.
REQ-010 out_valid  output  1  out_data holds a valid lane.
REQ-011 out_ready  input  1  downstream accepts the lane this cycle.
REQ-012 out_data  output  DATA_W  currently selected lane.
REQ-013 out_idx  output  SW  lane index of out_data; SW = max(1, $clog2(N)).
REQ-014 out_last  output  1  out_data is lane N-1.
REQ-015 busy  output  1  a captured vector is not yet fully delivered.

Function
REQ-016 The FSM SHALL have two states: IDLE and STREAM.
REQ-017 in_ready SHALL be 1 exactly when state is IDLE; busy SHALL be 1 exactly when state is STREAM.
REQ-018 In IDLE, in_valid && in_ready SHALL capture in_data into an internal N-lane register, set the index to 0, and enter STREAM on the next edge.
REQ-019 in_valid while in STREAM SHALL be ignored; the captured vector SHALL NOT change.
REQ-020 In STREAM, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0.
REQ-021 out_data SHALL equal captured lane[index], selected combinationally from registered state; out_idx SHALL equal index; out_last SHALL be (index == N-1) && out_valid.
REQ-022 The first out_valid SHALL appear the cycle after the input handshake (latency 1).
REQ-023 On out_valid && out_ready with index < N-1, index SHALL increment by 1.
REQ-024 On out_valid && out_ready with index == N-1, state SHALL return to IDLE and index SHALL return to 0.
REQ-025 Without out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-026 With N == 1, each accepted vector SHALL produce exactly one beat with out_idx 0 and out_last 1.
REQ-027 For sustained out_ready, one vector SHALL occupy N+1 cycles (N beats plus one IDLE accept cycle).
REQ-028 flush SHALL force IDLE and index 0 on the next edge from any state, discarding remaining lanes.
REQ-029 flush SHALL take priority over a simultaneous output or input handshake; an in_valid accompanying flush SHALL NOT be captured.
REQ-030 index SHALL never exceed N-1 and SHALL NOT wrap except via REQ-024/REQ-028.

Reset
REQ-031 While rst is 1, state SHALL be IDLE, index 0, the captured register all zeros, out_valid 0, out_last 0, busy 0, in_ready 1, out_idx 0, out_data 0.
REQ-032 Assertion of rst mid-STREAM SHALL take effect immediately without waiting for a clock edge; no further beats of that vector SHALL appear.

Verification
REQ-033 N=4, DATA_W=8, in_data=0x44332211, out_ready=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_idx 0..3, out_last only on 0x44, in_ready 1 again on the following cycle.
REQ-034 Same vector, out_ready toggled 1,0,0,1,1,0,1 -> each lane delivered exactly once in order, out_data stable during stalls.
REQ-035 in_valid held high with a second vector 0xDDCCBBAA during STREAM -> first vector delivered intact; second captured only after out_last handshake.
REQ-036 flush asserted together with the handshake of lane 1 -> lane 1 is not counted, IDLE next cycle, out_valid 0, in_ready 1.
REQ-037 rst pulsed asynchronously between edges during lane 2 -> out_valid and busy fall immediately, out_idx 0, the next accepted vector starts at lane 0.
REQ-038 N=1, DATA_W=32, in_data=0xCAFEF00D -> single beat 0xCAFEF00D with out_idx 0 and out_last 1, then IDLE.
